// File: rtl/instr_dispatch.sv
// -----------------------------------------------------------------------------
// instr_dispatch
//
// Single-entry dispatch stage between the instruction FIFO and the four issue
// queues (ALU, BRU, LSU, CSR) plus the reorder buffer. The FIFO head is popped
// into a hold register. From there it is dispatched to the queue selected by its
// 2-bit unit field, and a ROB entry is allocated in the same cycle.
//
// CSR instructions are serialising. They wait in SERIAL until the ROB has
// drained, and only then dispatch.
//
// Parameters:
//   DW        micro-instruction width
//   UNIT_LSB  LSB of the 2-bit unit field (00 ALU, 01 BRU, 10 LSU, 11 CSR)
//   TAG_W     ROB tag width
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   instrFifo_empty/_data/_pop    instruction FIFO head interface
//   flush                         pipeline flush, discards the held instruction
//   rob_full, rob_empty, rob_push ROB status and allocate strobe
//   {alu,bru,lsu,csr}_full/_push  issue-queue status and push strobes
//   dispatch_data, dispatch_tag   held micro-instruction and its ROB tag
//   stall_cnt                     cycles spent holding without dispatching
//
// Optional feature macro: DISPATCH_PERF_CNT_EN
//   When it is defined, the saturating stall counter is built.
//   When it is undefined, stall_cnt is tied to 0.
//
// Handshake: every push/pop output is a single-cycle strobe. The consumer
// must act on the rising edge that ends the cycle in which the strobe is high.
// A push is only raised when the matching *_full input is low in that same
// cycle, so *_full acts as the inverted ready. All strobes are forced low
// while RST is high.
// -----------------------------------------------------------------------------
module instr_dispatch #(
    parameter int DW       = 64,
    parameter int UNIT_LSB = 0,
    parameter int TAG_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instrFifo_empty,
    input  logic [DW-1:0]    instrFifo_data,
    output logic             instrFifo_pop,
    input  logic             flush,
    input  logic             rob_full,
    input  logic             rob_empty,
    output logic             rob_push,
    input  logic             alu_full,
    input  logic             bru_full,
    input  logic             lsu_full,
    input  logic             csr_full,
    output logic             alu_push,
    output logic             bru_push,
    output logic             lsu_push,
    output logic             csr_push,
    output logic [DW-1:0]    dispatch_data,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HELD   = 2'd1,
        ST_SERIAL = 2'd2
    } state_t;

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_BRU = 2'b01;
    localparam logic [1:0] UNIT_LSU = 2'b10;
    localparam logic [1:0] UNIT_CSR = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    hold_q;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       unit;
    logic             target_full;
    logic             fire;
    logic             pop;

    assign unit = hold_q[UNIT_LSB +: 2];

    always_comb begin
        target_full = alu_full;
        case (unit)
            UNIT_ALU: target_full = alu_full;
            UNIT_BRU: target_full = bru_full;
            UNIT_LSU: target_full = lsu_full;
            default:  target_full = csr_full;
        endcase
    end

    // Next-state and fire/pop decode.
    always_comb begin
        fire    = 1'b0;
        pop     = 1'b0;
        state_d = state_q;

        case (state_q)
            // A CSR head never fires from HELD. It first parks in SERIAL.
            ST_HELD:   fire = (unit != UNIT_CSR) && !target_full && !rob_full && !flush;
            ST_SERIAL: fire = rob_empty && !csr_full && !rob_full && !flush;
            default:   fire = 1'b0;
        endcase

        // Refill on the same cycle as a dispatch to sustain one instruction per cycle.
        pop = !instrFifo_empty && !flush && ((state_q == ST_EMPTY) || fire);

        case (state_q)
            ST_EMPTY: begin
                if (pop) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (fire)                  state_d = pop ? ST_HELD : ST_EMPTY;
                else if (unit == UNIT_CSR) state_d = ST_SERIAL;
                else                       state_d = ST_HELD;
            end
            ST_SERIAL: begin
                if (fire) state_d = pop ? ST_HELD : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) state_d = ST_EMPTY;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush)    hold_q <= '0;
            else if (pop) hold_q <= instrFifo_data;
            // The tag counter wraps naturally at 2^TAG_W.
            if (fire)     tag_q  <= tag_q + 1'b1;
        end
    end

    // Strobes are gated by RST so they are low for the whole reset pulse.
    // The state register alone would not guarantee this: it is already EMPTY
    // during reset, which would otherwise allow a pop.
    assign instrFifo_pop = pop && !RST;
    assign rob_push      = fire && !RST;
    assign alu_push      = fire && !RST && (unit == UNIT_ALU);
    assign bru_push      = fire && !RST && (unit == UNIT_BRU);
    assign lsu_push      = fire && !RST && (unit == UNIT_LSU);
    assign csr_push      = fire && !RST && (unit == UNIT_CSR);

    assign dispatch_data = hold_q;
    assign dispatch_tag  = tag_q;

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else if (((state_q == ST_HELD) || (state_q == ST_SERIAL)) && !fire &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// -----------------------------------------------------------------------------
// tb_instr_dispatch
//
// Directed bench for instr_dispatch.
//
// The FIFO is modelled as a queue. The driver pushes the expected dispatch
// record {rob_push, one-hot queue push, data, tag} into exp_q whenever it
// feeds an instruction that should reach an issue queue. A monitor on the
// falling edge pops exp_q and compares it each time the DUT raises any push.
//
// The driver also checks cycle-level behaviour directly: pop timing, stalls,
// flush, reset, and the stall counter.
//
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_instr_dispatch;

    localparam int DW    = 64;
    localparam int TAG_W = 4;
    localparam int EW    = 1 + 4 + DW + TAG_W;

    // Clock / reset
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic             instrFifo_empty;
    logic [DW-1:0]    instrFifo_data;
    logic             instrFifo_pop;
    logic             flush;
    logic             rob_full;
    logic             rob_empty;
    logic             rob_push;
    logic             alu_full, bru_full, lsu_full, csr_full;
    logic             alu_push, bru_push, lsu_push, csr_push;
    logic [DW-1:0]    dispatch_data;
    logic [TAG_W-1:0] dispatch_tag;
    logic [31:0]      stall_cnt;

    instr_dispatch #(.DW(DW), .UNIT_LSB(0), .TAG_W(TAG_W)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .instrFifo_empty (instrFifo_empty),
        .instrFifo_data  (instrFifo_data),
        .instrFifo_pop   (instrFifo_pop),
        .flush           (flush),
        .rob_full        (rob_full),
        .rob_empty       (rob_empty),
        .rob_push        (rob_push),
        .alu_full        (alu_full),
        .bru_full        (bru_full),
        .lsu_full        (lsu_full),
        .csr_full        (csr_full),
        .alu_push        (alu_push),
        .bru_push        (bru_push),
        .lsu_push        (lsu_push),
        .csr_push        (csr_push),
        .dispatch_data   (dispatch_data),
        .dispatch_tag    (dispatch_tag),
        .stall_cnt       (stall_cnt)
    );

    // Scoreboard state
    logic [EW-1:0]    exp_q[$];
    logic [DW-1:0]    fifo_q[$];
    logic [TAG_W-1:0] exp_tag;
    int               errors = 0;
    int               checks = 0;
    logic             pop_seen = 1'b0;

    function automatic logic [DW-1:0] mk(input logic [1:0] unit, input int id);
        return {16'hD15A, 16'(id), 16'(id * 3 + 1), 14'h1A5, unit};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        instrFifo_empty = (fifo_q.size() == 0);
        instrFifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic fifo_push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        fifo_refresh();
    endtask

    // Record an instruction that must later dispatch, with its hand-assigned tag.
    task automatic expect_dispatch(input logic [DW-1:0] d);
        logic [3:0] onehot;
        onehot = 4'b0001 << d[1:0];
        exp_q.push_back({1'b1, onehot, d, exp_tag});
        exp_tag = exp_tag + 1'b1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        pop_seen = instrFifo_pop;
    endtask

    task automatic to_next();
        @(posedge CLK);
        #1;
        if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_seen = 1'b0;
        fifo_refresh();
    endtask

    task automatic cyc();
        at_neg();
        to_next();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_pop",      64'(instrFifo_pop), 64'd0);
        chk("rst_rob_push", 64'(rob_push), 64'd0);
        chk("rst_q_push",   64'({alu_push, bru_push, lsu_push, csr_push}), 64'd0);
        chk("rst_tag",      64'(dispatch_tag), 64'd0);
        chk("rst_data",     dispatch_data, 64'd0);
        chk("rst_stall",    64'(stall_cnt), 64'd0);
        exp_tag = '0;
        cyc();
        RST = 1'b0;
    endtask

    // Monitor: every push seen on the DUT is checked against the head of exp_q.
    logic [3:0]    mon_obs;
    logic [EW-1:0] mon_exp;

    always @(negedge CLK) begin
        if (!RST) begin
            mon_obs = {csr_push, lsu_push, bru_push, alu_push};
            if (mon_obs != 4'd0 || rob_push) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dispatch: got push=%b rob=%b data=%0h tag=%0h expected none",
                             mon_obs, rob_push, dispatch_data, dispatch_tag);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({rob_push, mon_obs, dispatch_data, dispatch_tag} !== mon_exp) begin
                        errors++;
                        $display("FAIL dispatch: got rob=%b push=%b data=%0h tag=%0h expected rob=%b push=%b data=%0h tag=%0h",
                                 rob_push, mon_obs, dispatch_data, dispatch_tag,
                                 mon_exp[EW-1], mon_exp[EW-2 -: 4], mon_exp[TAG_W +: DW], mon_exp[TAG_W-1:0]);
                    end
                end
            end
        end
    end

    logic [DW-1:0]    d_held;
    logic [TAG_W-1:0] t_held;

    initial begin
        flush     = 1'b0;
        rob_full  = 1'b0;
        rob_empty = 1'b1;
        alu_full  = 1'b0;
        bru_full  = 1'b0;
        lsu_full  = 1'b0;
        csr_full  = 1'b0;
        exp_tag   = '0;
        fifo_refresh();

        do_reset();

        // Single ALU instruction: pop in cycle 0, dispatch in cycle 1 with tag 0.
        fifo_push(mk(2'b00, 1));
        expect_dispatch(mk(2'b00, 1));
        at_neg();
        chk("first_pop", 64'(instrFifo_pop), 64'd1);
        chk("first_no_push_c0", 64'(rob_push), 64'd0);
        to_next();
        at_neg();
        chk("first_alu_push", 64'(alu_push), 64'd1);
        chk("first_tag", 64'(dispatch_tag), 64'd0);
        to_next();
        cyc();

        // 20-instruction ALU/LSU stream from reset: one dispatch per cycle, tags wrap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            fifo_push(mk((i % 2 == 0) ? 2'b00 : 2'b10, 100 + i));
            expect_dispatch(mk((i % 2 == 0) ? 2'b00 : 2'b10, 100 + i));
        end
        at_neg();
        chk("stream_pop_c0", 64'(instrFifo_pop), 64'd1);
        to_next();
        for (int i = 0; i < 20; i++) begin
            at_neg();
            chk("stream_rob_push", 64'(rob_push), 64'd1);
            chk("stream_tag", 64'(dispatch_tag), 64'(i % 16));
            to_next();
        end
        at_neg();
        chk("stream_idle", 64'(rob_push), 64'd0);
        to_next();

        // BRU held with bru_full for 3 cycles: no pop, stable, dispatch in cycle 4.
        do_reset();
        d_held = mk(2'b01, 200);
        t_held = exp_tag;
        fifo_push(d_held);
        expect_dispatch(d_held);
        fifo_push(mk(2'b00, 201));
        expect_dispatch(mk(2'b00, 201));
        cyc();
        bru_full = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            at_neg();
            chk("bru_stall_pop", 64'(instrFifo_pop), 64'd0);
            chk("bru_stall_push", 64'(rob_push), 64'd0);
            chk("bru_stall_data", dispatch_data, d_held);
            chk("bru_stall_tag", 64'(dispatch_tag), 64'(t_held));
`ifdef DISPATCH_PERF_CNT_EN
            chk("bru_stall_cnt", 64'(stall_cnt), 64'(k - 1));
`else
            chk("bru_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
            to_next();
        end
        bru_full = 1'b0;
        at_neg();
        chk("bru_fire", 64'(bru_push), 64'd1);
        chk("bru_fire_pop", 64'(instrFifo_pop), 64'd1);
`ifdef DISPATCH_PERF_CNT_EN
        chk("bru_stall_total", 64'(stall_cnt), 64'd3);
`else
        chk("bru_stall_total", 64'(stall_cnt), 64'd0);
`endif
        to_next();
        at_neg();
        chk("bru_next_alu", 64'(alu_push), 64'd1);
        to_next();

        // CSR with rob_empty low for 5 cycles: serialised, no pop until it fires.
        rob_empty = 1'b0;
        fifo_push(mk(2'b11, 300));
        expect_dispatch(mk(2'b11, 300));
        fifo_push(mk(2'b00, 301));
        expect_dispatch(mk(2'b00, 301));
        cyc();
        for (int k = 1; k <= 5; k++) begin
            at_neg();
            chk("csr_wait_pop", 64'(instrFifo_pop), 64'd0);
            chk("csr_wait_push", 64'(rob_push), 64'd0);
            to_next();
        end
        rob_empty = 1'b1;
        at_neg();
        chk("csr_fire", 64'(csr_push), 64'd1);
        chk("csr_fire_pop", 64'(instrFifo_pop), 64'd1);
        to_next();
        at_neg();
        chk("csr_next_alu", 64'(alu_push), 64'd1);
        to_next();

        // Flush while an LSU instruction is held and could fire.
        t_held = exp_tag;
        fifo_push(mk(2'b10, 400));
        fifo_push(mk(2'b00, 401));
        expect_dispatch(mk(2'b00, 401));
        cyc();
        flush = 1'b1;
        at_neg();
        chk("flush_no_lsu", 64'(lsu_push), 64'd0);
        chk("flush_no_rob", 64'(rob_push), 64'd0);
        chk("flush_no_pop", 64'(instrFifo_pop), 64'd0);
        to_next();
        flush = 1'b0;
        at_neg();
        chk("flush_empty_pop", 64'(instrFifo_pop), 64'd1);
        chk("flush_tag_kept", 64'(dispatch_tag), 64'(t_held));
        to_next();
        at_neg();
        chk("flush_next_alu", 64'(alu_push), 64'd1);
        to_next();

        // Reset pulse while an instruction is held; the next one gets tag 0.
        alu_full = 1'b1;
        fifo_push(mk(2'b00, 500));
        cyc();
        at_neg();
        chk("pre_rst_held", dispatch_data, mk(2'b00, 500));
        to_next();
        fifo_push(mk(2'b00, 501));
        do_reset();
        alu_full = 1'b0;
        expect_dispatch(mk(2'b00, 501));
        at_neg();
        chk("post_rst_pop", 64'(instrFifo_pop), 64'd1);
        to_next();
        at_neg();
        chk("post_rst_tag", 64'(dispatch_tag), 64'd0);
        to_next();

        // Drain with a bounded wait.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending dispatches expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 SHALL have parameter DW, default 64, micro-instruction width (set to DECODE_INFO_DW at instantiation).
REQ-002 SHALL have parameter UNIT_LSB, default 0, LSB of the 2-bit unit field: 00 ALU, 01 BRU, 10 LSU, 11 CSR.
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 CLK  input  1  sole clock; all state on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 instrFifo_empty  input  1  instruction FIFO empty.
REQ-007 instrFifo_data  input  DW  FIFO head micro-instruction, valid while not empty.
REQ-008 instrFifo_pop  output  1  pop FIFO head this cycle.
REQ-009 flush  input  1  pipeline flush (mispredict/exception).
REQ-010 rob_full, rob_empty  input  1 each  ROB status.
REQ-011 rob_push  output  1  allocate ROB entry this cycle.
REQ-012 alu_full, bru_full, lsu_full, csr_full  input  1 each  issue-queue full.
REQ-013 alu_push, bru_push, lsu_push, csr_push  output  1 each  issue-queue push.
REQ-014 dispatch_data  output  DW  held micro-instruction.
REQ-015 dispatch_tag  output  TAG_W  ROB tag of held instruction.
REQ-016 stall_cnt  output  32  dispatch stall cycle counter.

Function
REQ-017 SHALL hold at most one instruction in a hold register; FSM states EMPTY, HELD, SERIAL.
REQ-018 instrFifo_pop SHALL be 1 iff !instrFifo_empty && !flush && (state==EMPTY || dispatch fires this cycle).
REQ-019 Popped data SHALL be in the hold register on the next edge (1-cycle pop-to-held latency).
REQ-020 Target queue = unit field; dispatch fires in HELD iff target full==0 && rob_full==0 && flush==0 && unit!=CSR.
REQ-021 Dispatch SHALL assert exactly one queue push and rob_push in the same cycle; all push outputs are otherwise 0.
REQ-022 Held instruction with unit CSR SHALL enter SERIAL; SERIAL fires only when rob_empty && !csr_full && !rob_full && !flush.
REQ-023 While in SERIAL, instrFifo_pop SHALL be 0 until the CSR dispatch cycle.
REQ-024 dispatch_tag SHALL come from a TAG_W counter that increments on each rob_push and wraps from 2^TAG_W-1 to 0.
REQ-025 Transitions: EMPTY->HELD on pop; HELD->EMPTY on fire without pop; HELD->HELD on fire with pop or no fire; HELD->SERIAL on CSR head; SERIAL->HELD/EMPTY on fire with/without pop.
REQ-026 flush SHALL, on the next edge, empty the hold register, go to EMPTY, and suppress pop, rob_push and queue pushes that cycle; tag counter unchanged.
REQ-027 Simultaneous fire and pop SHALL give back-to-back dispatch at 1 instruction/cycle.
REQ-028 A held instruction SHALL stay stable (data, tag) while stalled.

Reset
REQ-029 On RST: state EMPTY, tag counter 0, stall_cnt 0, hold register 0; all push/pop outputs 0 while RST is asserted.
REQ-030 RST asserted mid-operation SHALL discard the held instruction immediately (asynchronous).

Configuration
REQ-031 Macro DISPATCH_PERF_CNT_EN defined: stall_cnt increments (saturating at 2^32-1) each cycle state is HELD or SERIAL with no fire.
REQ-032 Macro undefined: stall_cnt SHALL be constant 0 and no counter logic is built.

Verification
REQ-033 Reset, FIFO holds ALU instr, all queues empty -> pop cycle 0, alu_push+rob_push cycle 1, tag 0.
REQ-034 Stream of 20 ALU/LSU instrs, no stalls -> one dispatch per cycle, tags 0..15,0..3 (wrap).
REQ-035 HELD BRU instr, bru_full=1 for 3 cycles -> no pop, data/tag stable, stall_cnt +3 (macro on), dispatch cycle 4.
REQ-036 CSR instr with rob_empty=0 for 5 cycles -> SERIAL, no pop, csr_push when rob_empty=1.
REQ-037 flush in a cycle with HELD LSU and lsu_full=0 -> no lsu_push, no pop, EMPTY next cycle, tag unchanged.
REQ-038 RST pulse while HELD -> all outputs 0, tag 0, next instruction gets tag 0.
